// File: rtl/weighted_sum_accumulator_pkg.sv
// Shared widths and FSM encoding for the weighted-sum accumulator that feeds
// the pipelined divider.
package weighted_sum_accumulator_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WEIGHT_W = 4;
  localparam int SUM_W    = 28;
  localparam int COUNT_W  = 20;
  localparam int PROD_W   = PIXEL_W + WEIGHT_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps at all-ones and flags when clamping happened.
module sat_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] full;

  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i};
    ovf_o = full[W];
    sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/weighted_sum_accumulator.sv
// Two-stage weighted-sum accumulator: stage 1 registers pixel*weight, stage 2
// accumulates the group and emits one StartOut pulse per completed group.
module weighted_sum_accumulator
  import weighted_sum_accumulator_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [PIXEL_W-1:0]  PixelIn,
  input  logic [WEIGHT_W-1:0] WeightIn,
  input  logic                ValidIn,
  input  logic                FirstIn,
  input  logic                LastIn,
  output logic [SUM_W-1:0]    DataOut,
  output logic [COUNT_W-1:0]  Divisor,
  output logic                StartOut,
  output logic                SatOut,
  output logic                ErrorOut
);

  logic                s1_valid_q;
  logic [PROD_W-1:0]   s1_prod_q;
  logic [WEIGHT_W-1:0] s1_weight_q;
  logic                s1_first_q;
  logic                s1_last_q;

  state_e              state_q, state_d;
  logic [SUM_W-1:0]    acc_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic                grp_sat_q;

  logic [SUM_W-1:0]    data_q;
  logic [COUNT_W-1:0]  div_q;
  logic                start_q, sat_out_q, error_q;

  logic [PROD_W-1:0]   prod;
  logic [SUM_W-1:0]    acc_base, acc_sum;
  logic [COUNT_W-1:0]  cnt_base, cnt_sum;
  logic                sum_ovf, cnt_ovf;
  logic                drop, take, emit, zero_total, grp_sat_d, err_set;

  assign prod = PROD_W'(PixelIn) * PROD_W'(WeightIn);

  // A beat carrying FirstIn always starts from zero, so a mid-group FirstIn
  // discards the partial totals instead of adding to them.
  assign acc_base = s1_first_q ? '0 : acc_q;
  assign cnt_base = s1_first_q ? '0 : cnt_q;

  sat_adder #(.W(SUM_W)) u_sum_add (
    .a_i   (acc_base),
    .b_i   (SUM_W'(s1_prod_q)),
    .sum_o (acc_sum),
    .ovf_o (sum_ovf)
  );

  sat_adder #(.W(COUNT_W)) u_cnt_add (
    .a_i   (cnt_base),
    .b_i   (COUNT_W'(s1_weight_q)),
    .sum_o (cnt_sum),
    .ovf_o (cnt_ovf)
  );

  always_comb begin
    state_d    = state_q;
    drop       = s1_valid_q && (state_q == ST_IDLE) && !s1_first_q;
    take       = s1_valid_q && !drop;
    emit       = take && s1_last_q;
    zero_total = (cnt_sum == '0);
    grp_sat_d  = (s1_first_q ? 1'b0 : grp_sat_q) | sum_ovf | cnt_ovf;
    err_set    = drop
              || (take && (state_q == ST_ACCUM) && s1_first_q)
              || (emit && zero_total);
    if (take) begin
      state_d = s1_last_q ? ST_IDLE : ST_ACCUM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_weight_q <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      grp_sat_q   <= 1'b0;
      data_q      <= '0;
      div_q       <= '0;
      start_q     <= 1'b0;
      sat_out_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      s1_valid_q <= ValidIn;
      if (ValidIn) begin
        s1_prod_q   <= prod;
        s1_weight_q <= WeightIn;
        s1_first_q  <= FirstIn;
        s1_last_q   <= LastIn;
      end
      state_q <= state_d;
      if (take) begin
        acc_q     <= acc_sum;
        cnt_q     <= cnt_sum;
        grp_sat_q <= grp_sat_d;
      end
      // A zero weight total never reaches the divider; outputs keep the last group.
      start_q   <= emit && !zero_total;
      sat_out_q <= emit && !zero_total && grp_sat_d;
      if (emit && !zero_total) begin
        data_q <= acc_sum;
        div_q  <= cnt_sum;
      end
      if (err_set) begin
        error_q <= 1'b1;
      end
    end
  end

  assign DataOut  = data_q;
  assign Divisor  = div_q;
  assign StartOut = start_q;
  assign SatOut   = sat_out_q;
  assign ErrorOut = error_q;

endmodule

// File: tb/tb_weighted_sum_accumulator.sv
// Directed bench for weighted_sum_accumulator: each scenario task drives beats
// and compares captured StartOut pulses against hand-computed totals.
module tb_weighted_sum_accumulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  PixelIn = '0;
  logic [3:0]  WeightIn = '0;
  logic        ValidIn = 1'b0;
  logic        FirstIn = 1'b0;
  logic        LastIn = 1'b0;
  logic [27:0] DataOut;
  logic [19:0] Divisor;
  logic        StartOut;
  logic        SatOut;
  logic        ErrorOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [27:0] cap_data[$];
  logic [19:0] cap_div[$];
  logic        cap_sat[$];
  int          cap_cyc[$];

  weighted_sum_accumulator dut (
    .clock    (clock),
    .reset    (reset),
    .PixelIn  (PixelIn),
    .WeightIn (WeightIn),
    .ValidIn  (ValidIn),
    .FirstIn  (FirstIn),
    .LastIn   (LastIn),
    .DataOut  (DataOut),
    .Divisor  (Divisor),
    .StartOut (StartOut),
    .SatOut   (SatOut),
    .ErrorOut (ErrorOut)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Pulse capture, sampled on the falling edge
  always @(negedge clock) begin
    if (StartOut === 1'b1) begin
      cap_data.push_back(DataOut);
      cap_div.push_back(Divisor);
      cap_sat.push_back(SatOut);
      cap_cyc.push_back(cyc);
    end
  end

  // Driver tasks: called at a falling edge, return at the next falling edge
  task automatic beat(input logic [7:0] p, input logic [3:0] w, input logic f, input logic l);
    PixelIn = p; WeightIn = w; FirstIn = f; LastIn = l; ValidIn = 1'b1;
    @(negedge clock);
    ValidIn = 1'b0; FirstIn = 1'b0; LastIn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++; if (DataOut !== 28'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", DataOut); end
    checks++; if (Divisor !== 20'd0) begin errors++; $display("FAIL reset_div got %0d exp 0", Divisor); end
    checks++; if ({StartOut, SatOut, ErrorOut} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {StartOut, SatOut, ErrorOut}); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_group();
    int t_last;
    beat(8'd100, 4'd1, 1'b1, 1'b0);
    beat(8'd100, 4'd1, 1'b0, 1'b0);
    beat(8'd100, 4'd1, 1'b0, 1'b0);
    t_last = cyc;
    beat(8'd100, 4'd1, 1'b0, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 1) begin errors++; $display("FAIL basic_pulse_count got %0d exp 1", cap_data.size()); end
    if (cap_data.size() > 0) begin
      checks++; if (cap_data[0] !== 28'd400) begin errors++; $display("FAIL basic_data got %0d exp 400", cap_data[0]); end
      checks++; if (cap_div[0] !== 20'd4) begin errors++; $display("FAIL basic_div got %0d exp 4", cap_div[0]); end
      checks++; if (cap_sat[0] !== 1'b0) begin errors++; $display("FAIL basic_sat got %b exp 0", cap_sat[0]); end
      checks++; if (cap_cyc[0] !== t_last + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cap_cyc[0], t_last + 2); end
    end
    checks++; if ({DataOut, StartOut, ErrorOut} !== {28'd400, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_hold got %0d/%b/%b exp 400/0/0", DataOut, StartOut, ErrorOut); end
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
  endtask

  task automatic test_single_beat();
    beat(8'd255, 4'd15, 1'b1, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 1) begin errors++; $display("FAIL single_pulse_count got %0d exp 1", cap_data.size()); end
    if (cap_data.size() > 0) begin
      checks++; if (cap_data[0] !== 28'd3825) begin errors++; $display("FAIL single_data got %0d exp 3825", cap_data[0]); end
      checks++; if (cap_div[0] !== 20'd15) begin errors++; $display("FAIL single_div got %0d exp 15", cap_div[0]); end
      checks++; if (cap_sat[0] !== 1'b0) begin errors++; $display("FAIL single_sat got %b exp 0", cap_sat[0]); end
    end
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3;
    beat(8'd10, 4'd2, 1'b1, 1'b0);
    t1 = cyc;
    beat(8'd10, 4'd2, 1'b0, 1'b1);
    beat(8'd10, 4'd2, 1'b1, 1'b0);
    beat(8'd10, 4'd2, 1'b0, 1'b0);
    t2 = cyc;
    beat(8'd10, 4'd2, 1'b0, 1'b1);
    t3 = cyc;
    beat(8'd5, 4'd1, 1'b1, 1'b1);
    beat(8'd6, 4'd2, 1'b1, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL b2b_pulse_count got %0d exp 4", cap_data.size()); end
    if (cap_data.size() == 4) begin
      checks++; if ({cap_data[0], cap_div[0]} !== {28'd40, 20'd4}) begin errors++; $display("FAIL b2b_group1 got %0d/%0d exp 40/4", cap_data[0], cap_div[0]); end
      checks++; if ({cap_data[1], cap_div[1]} !== {28'd60, 20'd6}) begin errors++; $display("FAIL b2b_group2 got %0d/%0d exp 60/6", cap_data[1], cap_div[1]); end
      checks++; if ({cap_data[2], cap_div[2]} !== {28'd5, 20'd1}) begin errors++; $display("FAIL b2b_one_beat_a got %0d/%0d exp 5/1", cap_data[2], cap_div[2]); end
      checks++; if ({cap_data[3], cap_div[3]} !== {28'd12, 20'd2}) begin errors++; $display("FAIL b2b_one_beat_b got %0d/%0d exp 12/2", cap_data[3], cap_div[3]); end
      checks++; if (cap_cyc[0] !== t1 + 2 || cap_cyc[1] !== t2 + 2) begin errors++; $display("FAIL b2b_timing got %0d,%0d exp %0d,%0d", cap_cyc[0], cap_cyc[1], t1 + 2, t2 + 2); end
      checks++; if (cap_cyc[2] !== t3 + 2 || cap_cyc[3] !== t3 + 3) begin errors++; $display("FAIL b2b_adjacent got %0d,%0d exp %0d,%0d", cap_cyc[2], cap_cyc[3], t3 + 2, t3 + 3); end
    end
    checks++; if (ErrorOut !== 1'b0) begin errors++; $display("FAIL b2b_error got %b exp 0", ErrorOut); end
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
  endtask

  task automatic test_zero_weight();
    beat(8'd9, 4'd0, 1'b1, 1'b0);
    beat(8'd9, 4'd0, 1'b0, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 0) begin errors++; $display("FAIL zero_no_pulse got %0d pulses exp 0", cap_data.size()); end
    checks++; if (ErrorOut !== 1'b1) begin errors++; $display("FAIL zero_error got %b exp 1", ErrorOut); end
    checks++; if ({DataOut, Divisor} !== {28'd12, 20'd2}) begin errors++; $display("FAIL zero_hold got %0d/%0d exp 12/2", DataOut, Divisor); end
    beat(8'd1, 4'd1, 1'b1, 1'b1);
    idle(6);
    checks++; if (ErrorOut !== 1'b1) begin errors++; $display("FAIL zero_sticky got %b exp 1", ErrorOut); end
    apply_reset();
    checks++; if (ErrorOut !== 1'b0) begin errors++; $display("FAIL zero_reset_clear got %b exp 0", ErrorOut); end
  endtask

  task automatic test_restart();
    beat(8'd50, 4'd1, 1'b1, 1'b0);
    beat(8'd50, 4'd1, 1'b0, 1'b0);
    idle(3);
    checks++; if (ErrorOut !== 1'b0) begin errors++; $display("FAIL restart_pre_error got %b exp 0", ErrorOut); end
    beat(8'd7, 4'd3, 1'b1, 1'b0);
    beat(8'd7, 4'd3, 1'b0, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 1) begin errors++; $display("FAIL restart_pulse_count got %0d exp 1", cap_data.size()); end
    if (cap_data.size() > 0) begin
      checks++; if ({cap_data[0], cap_div[0]} !== {28'd42, 20'd6}) begin errors++; $display("FAIL restart_totals got %0d/%0d exp 42/6", cap_data[0], cap_div[0]); end
    end
    checks++; if (ErrorOut !== 1'b1) begin errors++; $display("FAIL restart_error got %b exp 1", ErrorOut); end
    apply_reset();
  endtask

  task automatic test_saturation();
    // 70178 beats of 255*15 plus two of 255*9 bring the sum to 2^28-16;
    // the weight total passes 2^20-1 along the way.
    beat(8'd255, 4'd15, 1'b1, 1'b0);
    for (int i = 1; i < 70178; i++) beat(8'd255, 4'd15, 1'b0, 1'b0);
    beat(8'd255, 4'd9, 1'b0, 1'b0);
    beat(8'd255, 4'd9, 1'b0, 1'b0);
    beat(8'd255, 4'd15, 1'b0, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 1) begin errors++; $display("FAIL sat_pulse_count got %0d exp 1", cap_data.size()); end
    if (cap_data.size() > 0) begin
      checks++; if (cap_data[0] !== 28'hFFFFFFF) begin errors++; $display("FAIL sat_data got %h exp fffffff", cap_data[0]); end
      checks++; if (cap_div[0] !== 20'hFFFFF) begin errors++; $display("FAIL sat_div got %h exp fffff", cap_div[0]); end
      checks++; if (cap_sat[0] !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", cap_sat[0]); end
    end
    checks++; if (SatOut !== 1'b0) begin errors++; $display("FAIL sat_only_with_start got %b exp 0", SatOut); end
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
    // Next group clears the saturation flag
    beat(8'd2, 4'd2, 1'b1, 1'b1);
    idle(4);
    checks++; if (cap_sat.size() !== 1 || cap_sat[0] !== 1'b0 || cap_data[0] !== 28'd4) begin errors++; $display("FAIL sat_clear got %0d pulses exp 1 pulse 4 sat 0", cap_sat.size()); end
    cap_data.delete(); cap_div.delete(); cap_sat.delete(); cap_cyc.delete();
    // Reset mid-group: the group, including a Last beat coinciding with reset, is lost
    beat(8'd1, 4'd1, 1'b1, 1'b0);
    beat(8'd1, 4'd1, 1'b0, 1'b0);
    reset = 1'b1;
    beat(8'd2, 4'd1, 1'b0, 1'b1);
    idle(1);
    reset = 1'b0;
    idle(4);
    checks++; if (cap_data.size() !== 0) begin errors++; $display("FAIL reset_mid_no_pulse got %0d pulses exp 0", cap_data.size()); end
    checks++; if ({DataOut, Divisor, SatOut, ErrorOut} !== 51'd0) begin errors++; $display("FAIL reset_mid_outputs got %0d/%0d/%b/%b exp 0/0/0/0", DataOut, Divisor, SatOut, ErrorOut); end
    // First beat after reset lacks FirstIn: dropped and flagged
    beat(8'd3, 4'd1, 1'b0, 1'b1);
    idle(4);
    checks++; if (cap_data.size() !== 0 || ErrorOut !== 1'b1) begin errors++; $display("FAIL post_reset_drop got %0d pulses err %b exp 0 pulses err 1", cap_data.size(), ErrorOut); end
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_single_beat();
    test_back_to_back();
    test_zero_weight();
    test_restart();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
